// File: rtl/alu_arbiter_if.sv
// Requester-side request/response channels of the shared-ALU arbiter.
// master = the two requesters, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
);
    logic              req_valid_0;
    logic              req_valid_1;
    logic              req_ready_0;
    logic              req_ready_1;
    logic [DATA_W-1:0] req_input_1_0;
    logic [DATA_W-1:0] req_input_1_1;
    logic [DATA_W-1:0] req_input_2_0;
    logic [DATA_W-1:0] req_input_2_1;
    logic [CTRL_W-1:0] req_alu_control_0;
    logic [CTRL_W-1:0] req_alu_control_1;
    logic              rsp_valid_0;
    logic              rsp_valid_1;
    logic              rsp_ready_0;
    logic              rsp_ready_1;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport master (
        output req_valid_0, req_valid_1,
        input  req_ready_0, req_ready_1,
        output req_input_1_0, req_input_1_1, req_input_2_0, req_input_2_1,
        output req_alu_control_0, req_alu_control_1,
        input  rsp_valid_0, rsp_valid_1,
        output rsp_ready_0, rsp_ready_1,
        input  rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid_0, req_valid_1,
        output req_ready_0, req_ready_1,
        input  req_input_1_0, req_input_1_1, req_input_2_0, req_input_2_1,
        input  req_alu_control_0, req_alu_control_1,
        output rsp_valid_0, rsp_valid_1,
        input  rsp_ready_0, rsp_ready_1,
        output rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional per-requester saturating grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_input_1,
    output logic [DATA_W-1:0] alu_input_2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt_0,
    output logic [CNT_W-1:0]  grant_cnt_1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant_any;
    logic   grant_sel;

    // Grant decision: a lone requester always wins; a tie goes to whoever was not served last.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE) begin
            grant_any = bus.req_valid_0 | bus.req_valid_1;
            grant_sel = (bus.req_valid_0 & bus.req_valid_1) ? ~last_grant : bus.req_valid_1;
        end
        bus.req_ready_0 = grant_any & ~grant_sel;
        bus.req_ready_1 = grant_any & grant_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            alu_input_1     <= '0;
            alu_input_2     <= '0;
            alu_control     <= '0;
            bus.rsp_result  <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_valid_0 <= 1'b0;
            bus.rsp_valid_1 <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_input_1 <= grant_sel ? bus.req_input_1_1 : bus.req_input_1_0;
                        alu_input_2 <= grant_sel ? bus.req_input_2_1 : bus.req_input_2_0;
                        alu_control <= grant_sel ? bus.req_alu_control_1 : bus.req_alu_control_0;
                        last_grant  <= grant_sel;
                        owner       <= grant_sel;
                        busy        <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_result  <= alu_result;
                    bus.rsp_zero    <= alu_zero;
                    bus.rsp_valid_0 <= ~owner;
                    bus.rsp_valid_1 <= owner;
                    state           <= RESP;
                end
                RESP: begin
                    // Only the owner's ready completes the response.
                    if (owner ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
                        bus.rsp_valid_0 <= 1'b0;
                        bus.rsp_valid_1 <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating accept counters; readiness implies acceptance in this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
        end else begin
            if (bus.req_ready_0 && (grant_cnt_0 != '1)) begin
                grant_cnt_0 <= grant_cnt_0 + CNT_W'(1);
            end
            if (bus.req_ready_1 && (grant_cnt_1 != '1)) begin
                grant_cnt_1 <= grant_cnt_1 + CNT_W'(1);
            end
        end
    end
`else
    assign grant_cnt_0 = '0;
    assign grant_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests, a behavioural ALU,
// and a monitor that checks every response handshake against queued expectations.
module tb_alu_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    logic [DATA_W-1:0] alu_input_1, alu_input_2, alu_result;
    logic [CTRL_W-1:0] alu_control;
    logic              alu_zero, busy;
    logic [CNT_W-1:0]  grant_cnt_0, grant_cnt_1;

    alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_input_1 (alu_input_1),
        .alu_input_2 (alu_input_2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy),
        .grant_cnt_0 (grant_cnt_0),
        .grant_cnt_1 (grant_cnt_1)
    );

    // Behavioural 32-bit ALU
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_input_1 + alu_input_2;
            4'b0001: alu_result = alu_input_1 - alu_input_2;
            4'b0010: alu_result = alu_input_1 & alu_input_2;
            4'b0011: alu_result = alu_input_1 | alu_input_2;
            4'b0100: alu_result = ($signed(alu_input_1) < $signed(alu_input_2)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic        ch;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc0 = 0;
    int   acc1 = 0;
    int   v0_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_cnt(input int n);
`ifdef ALU_ARB_STATS_EN
        return (n > 3) ? 3 : n;
`else
        return (n > 0) ? 0 : 0;
`endif
    endfunction

    // Monitor: structural invariants every cycle, scoreboard pop on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid_0) v0_seen++;
            check("rsp_valid_onehot", 32'(bus.rsp_valid_0 & bus.rsp_valid_1), 0);
            check("req_ready_onehot", 32'(bus.req_ready_0 & bus.req_ready_1), 0);
            if (busy) check("no_ready_when_busy", 32'(bus.req_ready_0 | bus.req_ready_1), 0);
            if ((bus.rsp_valid_0 && bus.rsp_ready_0) || (bus.rsp_valid_1 && bus.rsp_ready_1)) begin
                check("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_channel", 32'(bus.rsp_valid_1), 32'(mon_e.ch));
                    check("rsp_result", bus.rsp_result, mon_e.res);
                    check("rsp_zero", 32'(bus.rsp_zero), 32'(mon_e.zero));
                end
            end
        end
    end

    task automatic drive(input bit k, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        if (k) begin
            bus.req_valid_1 = v; bus.req_input_1_1 = a; bus.req_input_2_1 = b; bus.req_alu_control_1 = op;
        end else begin
            bus.req_valid_0 = v; bus.req_input_1_0 = a; bus.req_input_2_0 = b; bus.req_alu_control_0 = op;
        end
    endtask

    // Wait for requester k's ready, queue its expected response, then drop valid.
    task automatic accept(input bit k, input logic [31:0] er, input bit ez, output int w);
        bit got = 0;
        w = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (k ? bus.req_ready_1 : bus.req_ready_0) begin
                got = 1;
                break;
            end
            w++;
        end
        check("accept_seen", 32'(got), 1);
        if (got) begin
            sb.push_back('{ch: k, res: er, zero: ez});
            if (k) acc1++; else acc0++;
        end
        @(posedge clk); #1;
        if (k) bus.req_valid_1 = 1'b0; else bus.req_valid_0 = 1'b0;
    endtask

    task automatic issue(input bit k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] er, input bit ez, output int w);
        @(posedge clk); #1;
        drive(k, 1'b1, a, b, op);
        accept(k, er, ez, w);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        check("idle_reached", 32'(done), 1);
    endtask

    logic [31:0] rr_a [2][2] = '{'{32'hF0, 32'h100}, '{32'hA0, 32'h0}};
    logic [31:0] rr_b [2][2] = '{'{32'h0F, 32'h001}, '{32'h05, 32'h0}};
    logic [31:0] rr_e [2][2] = '{'{32'hFF, 32'h101}, '{32'hA5, 32'h0}};
    logic        rr_z [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b1}};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int idx [2];
        bit k;
        bit got;
        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;

        // Reset state
        #12;
        check("rst_req_ready_0", 32'(bus.req_ready_0), 0);
        check("rst_rsp_valid_0", 32'(bus.rsp_valid_0), 0);
        check("rst_rsp_valid_1", 32'(bus.rsp_valid_1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu_input_1", alu_input_1, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_grant_cnt_0", 32'(grant_cnt_0), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single add with latency checks
        issue(0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, w);
        check("add_ready_same_cycle", w, 0);
        @(negedge clk);
        check("add_exec_rsp_valid", 32'(bus.rsp_valid_0), 0);
        check("add_exec_busy", 32'(busy), 1);
        check("add_alu_input_1", alu_input_1, 32'd5);
        check("add_alu_input_2", alu_input_2, 32'd7);
        @(negedge clk);
        check("add_rsp_valid_latency", 32'(bus.rsp_valid_0), 1);
        wait_idle();
        check("idle_alu_hold", alu_input_1, 32'd5);

        // Zero flag on requester 1; channel 0 must stay silent
        v0_seen = 0;
        issue(1, 32'd9, 32'd9, 4'b0001, 32'd0, 1'b1, w);
        check("sub_ready_same_cycle", w, 0);
        wait_idle();
        check("sub_rsp_valid_0_quiet", v0_seen, 0);

        // Undefined op code passes through; signed slt
        issue(0, 32'd3, 32'd4, 4'hF, 32'd0, 1'b1, w);
        @(negedge clk);
        check("undef_op_passthrough", 32'(alu_control), 32'hF);
        wait_idle();
        issue(1, 32'hFFFF_FFFF, 32'd1, 4'b0100, 32'd1, 1'b0, w);
        wait_idle();

        // Round robin with both requesters continuously valid
        idx[0] = 0; idx[1] = 0;
        @(posedge clk); #1;
        drive(0, 1'b1, rr_a[0][0], rr_b[0][0], 4'b0011);
        drive(1, 1'b1, rr_a[1][0], rr_b[1][0], 4'b0011);
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.req_ready_0 || bus.req_ready_1) begin
                    got = 1;
                    break;
                end
            end
            check("rr_accept_seen", 32'(got), 1);
            if (!got) break;
            k = bus.req_ready_1;
            check("rr_grant", 32'(k), 32'(g % 2));
            sb.push_back('{ch: k, res: rr_e[k][idx[k]], zero: rr_z[k][idx[k]]});
            if (k) acc1++; else acc0++;
            idx[k]++;
            @(posedge clk); #1;
            if (idx[k] == 2) drive(k, 1'b0, 0, 0, 0);
            else drive(k, 1'b1, rr_a[k][idx[k]], rr_b[k][idx[k]], 4'b0011);
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        wait_idle();

        // Response backpressure while requester 1 waits
        bus.rsp_ready_0 = 1'b0;
        issue(0, 32'hFF00, 32'h0FF0, 4'b0010, 32'h0F00, 1'b0, w);
        drive(1, 1'b1, 32'd20, 32'd3, 4'b0001);
        got = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.rsp_valid_0) begin
                got = 1;
                break;
            end
        end
        check("bp_rsp_valid_seen", 32'(got), 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_result_stable", bus.rsp_result, 32'h0F00);
            check("bp_busy", 32'(busy), 1);
            check("bp_req_ready_1", 32'(bus.req_ready_1), 0);
            check("bp_rsp_valid_0", 32'(bus.rsp_valid_0), 1);
        end
        @(posedge clk); #1 bus.rsp_ready_0 = 1'b1;
        @(negedge clk);
        check("bp_handshake_cycle_ready_1", 32'(bus.req_ready_1), 0);
        @(negedge clk);
        check("bp_grant_after_handshake", 32'(bus.req_ready_1), 1);
        if (bus.req_ready_1) begin
            sb.push_back('{ch: 1'b1, res: 32'd17, zero: 1'b0});
            acc1++;
        end
        @(posedge clk); #1 drive(1, 1'b0, 0, 0, 0);
        wait_idle();

        // Reset while the response is pending
        bus.rsp_ready_0 = 1'b0;
        issue(0, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, w);
        got = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.rsp_valid_0) begin
                got = 1;
                break;
            end
        end
        check("rr_rsp_pending", 32'(got), 1);
        #2 rst_n = 1'b0;
        sb.delete();
        acc0 = 0; acc1 = 0;
        #1;
        check("mid_rst_rsp_valid_0", 32'(bus.rsp_valid_0), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rsp_result", bus.rsp_result, 0);
        check("mid_rst_alu_input_2", alu_input_2, 0);
        check("mid_rst_alu_control", 32'(alu_control), 0);
        check("mid_rst_grant_cnt_0", 32'(grant_cnt_0), 0);
        bus.rsp_ready_0 = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 1'b1, 32'd10, 32'd4, 4'b0001);
        drive(1, 1'b1, 32'd2, 32'd2, 4'b0010);
        @(negedge clk);
        check("post_rst_tie_0", 32'(bus.req_ready_0), 1);
        check("post_rst_tie_not_1", 32'(bus.req_ready_1), 0);
        if (bus.req_ready_0) begin
            sb.push_back('{ch: 1'b0, res: 32'd6, zero: 1'b0});
            acc0++;
        end
        @(posedge clk); #1 drive(0, 1'b0, 0, 0, 0);
        accept(1, 32'd2, 1'b0, w);
        wait_idle();

        // Grant statistics with a narrow counter
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'(i), 32'(i), 4'b0000, 32'(2 * i), (i == 0), w);
            wait_idle();
        end
        check("grant_cnt_0", 32'(grant_cnt_0), 32'(sat_cnt(acc0)));
        check("grant_cnt_1", 32'(grant_cnt_1), 32'(sat_cnt(acc1)));
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
